dm_cache_ctrl: RTL and testbench

- Direct-mapped, write-through, no-write-allocate cache between the CPU load/store port and the word-addressed `memory` block.
- On a read miss it fetches the whole 4-word line that `memory` returns on its 128-bit data_out.
- Gives single-cycle hits and a fixed 2-cycle miss penalty.
- Exposes hit and miss counters for performance inspection.

---
 rtl/cache_pkg.sv | 22 ++
 rtl/cache_line_store.sv | 51 +++++
 rtl/dm_cache_ctrl.sv | 125 ++++++++++++
 tb/tb_dm_cache_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared widths, controller state encoding and line/word helpers for the
// direct-mapped write-through cache.
package cache_pkg;

    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 4;
    localparam int LINE_W         = WORD_W * WORDS_PER_LINE;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        REPLAY
    } state_e;

    // Packed element 3 holds word offset 0, matching memory's data_out ordering.
    typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_t;

    function automatic logic [WORD_W-1:0] word_sel(input line_t line, input logic [1:0] off);
        return line[~off];
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays: combinational read of one line, synchronous line fill,
// synchronous single-word store update and a synchronous clear of all valid bits.
module cache_line_store
    import cache_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 10
) (
    input  logic                  clock,
    input  logic                  clr_i,
    input  logic [INDEX_BITS-1:0] idx_i,
    output logic                  vld_o,
    output logic [TAG_BITS-1:0]   tag_o,
    output line_t                 line_o,
    input  logic                  fill_we_i,
    input  logic [TAG_BITS-1:0]   fill_tag_i,
    input  line_t                 fill_line_i,
    input  logic                  word_we_i,
    input  logic [1:0]            word_off_i,
    input  logic [WORD_W-1:0]     word_i
);

    localparam int LINES = 2 ** INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    line_t               data_q [LINES];

    assign vld_o  = valid_q[idx_i];
    assign tag_o  = tag_q[idx_i];
    assign line_o = data_q[idx_i];

    always_ff @(posedge clock) begin
        if (clr_i) begin
            valid_q <= '0;
        end else if (fill_we_i) begin
            valid_q[idx_i] <= 1'b1;
        end
    end

    // Tags and data need no reset; the valid bits gate every use of them.
    always_ff @(posedge clock) begin
        if (fill_we_i) begin
            tag_q[idx_i]  <= fill_tag_i;
            data_q[idx_i] <= fill_line_i;
        end else if (word_we_i) begin
            data_q[idx_i][~word_off_i] <= word_i;
        end
    end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with a
// fixed two-stall-cycle read miss and read hit/miss counters.
module dm_cache_ctrl
    import cache_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 14 - INDEX_BITS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    state_e               state_q, state_d;
    logic [31:0]          hit_q, hit_d;
    logic [31:0]          miss_q, miss_d;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic                  line_vld;
    logic [TAG_BITS-1:0]   line_tag;
    line_t                 line_data;
    logic                  hit;
    logic                  fill_we;
    logic                  word_we;

    assign idx = cpu_addr[INDEX_BITS+1:2];
    assign tag = cpu_addr[15:2+INDEX_BITS];
    assign hit = line_vld && (line_tag == tag);

    cache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_store (
        .clock       (clock),
        .clr_i       (reset),
        .idx_i       (idx),
        .vld_o       (line_vld),
        .tag_o       (line_tag),
        .line_o      (line_data),
        .fill_we_i   (fill_we),
        .fill_tag_i  (tag),
        .fill_line_i (mem_rdata),
        .word_we_i   (word_we),
        .word_off_i  (cpu_addr[1:0]),
        .word_i      (cpu_wdata)
    );

    always_comb begin
        state_d   = state_q;
        hit_d     = hit_q;
        miss_d    = miss_q;
        cpu_stall = 1'b0;
        cpu_rdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        fill_we   = 1'b0;
        word_we   = 1'b0;

        unique case (state_q)
            IDLE, REPLAY: begin
                // REPLAY is IDLE with the held read now guaranteed to hit uncounted.
                state_d = IDLE;
                if (cpu_write) begin
                    mem_write = 1'b1;
                    word_we   = hit;
                end else if (cpu_read) begin
                    if (hit) begin
                        cpu_rdata = word_sel(line_data, cpu_addr[1:0]);
                        if (state_q == IDLE) hit_d = hit_q + 32'd1;
                    end else begin
                        cpu_stall = 1'b1;
                        mem_read  = 1'b1;
                        mem_addr  = {cpu_addr[31:2], 2'b00};
                        miss_d    = miss_q + 32'd1;
                        state_d   = FILL;
                    end
                end
            end
            FILL: begin
                cpu_stall = 1'b1;
                fill_we   = 1'b1;
                state_d   = REPLAY;
            end
            default: state_d = IDLE;
        endcase

        if (reset) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            fill_we   = 1'b0;
            word_we   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench: a word memory with registered line reads, a cache-transparent
// reference model (loads return the current memory word) and one compare process.
module tb_dm_cache_ctrl;

    logic         clock = 1'b0;
    logic         reset;
    logic         cpu_read, cpu_write;
    logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic         cpu_stall, mem_read, mem_write;
    logic [31:0]  mem_addr, mem_wdata;
    logic [127:0] mem_rdata;
    logic [31:0]  hit_count, miss_count;

    always #5 clock = ~clock;

    dm_cache_ctrl #(.INDEX_BITS(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    // 64K-word memory: a read registers the aligned 4-word line, offset 0 in the top word.
    logic [31:0] ram [0:65535];
    always @(posedge clock) begin
        logic [15:0] b;
        b = {mem_addr[15:2], 2'b00};
        if (mem_write) ram[mem_addr[15:0]] <= mem_wdata;
        if (mem_read) mem_rdata <= {ram[b], ram[b+16'd1], ram[b+16'd2], ram[b+16'd3]};
    end

    always @(posedge clock)
        if (!reset && cpu_stall && cpu_write)
            $error("store presented while stalled");

    // Reference model: memory contents, which lines hold which tag, event counts.
    logic [31:0] gold [0:65535];
    bit          mvld [16];
    logic [9:0]  mtag [16];
    int unsigned mhit, mmiss;

    int n_cmp = 0;
    int n_bad = 0;

    // Per-cycle expectations consumed by the compare process.
    bit          e_en, e_stall_en, e_maddr_en, e_mwdata_en, e_rd_en, e_lit_en;
    logic        e_stall, e_mr, e_mw;
    logic [31:0] e_maddr, e_mwdata, e_rdata, e_lit;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    always @(negedge clock) begin
        if (e_en) begin
            if (e_stall_en)  chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, e_stall});
            chk("mem_read", {31'd0, mem_read}, {31'd0, e_mr});
            chk("mem_write", {31'd0, mem_write}, {31'd0, e_mw});
            if (e_maddr_en)  chk("mem_addr", mem_addr, e_maddr);
            if (e_mwdata_en) chk("mem_wdata", mem_wdata, e_mwdata);
            if (e_rd_en)     chk("cpu_rdata", cpu_rdata, e_rdata);
            if (e_lit_en)    chk("rdata_literal", cpu_rdata, e_lit);
            chk("hit_count", hit_count, mhit);
            chk("miss_count", miss_count, mmiss);
        end
    end

    task automatic exp_clear();
        e_en = 1'b1; e_stall_en = 1'b1; e_maddr_en = 1'b0; e_mwdata_en = 1'b0;
        e_rd_en = 1'b0; e_lit_en = 1'b0; e_stall = 1'b0; e_mr = 1'b0; e_mw = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] lit);
        int         i;
        logic [9:0] t;
        bit         h;
        i = int'(a[5:2]);
        t = a[15:6];
        h = mvld[i] && (mtag[i] == t);
        cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = a; cpu_wdata = $urandom;
        exp_clear();
        if (h) begin
            e_rd_en = 1'b1; e_rdata = gold[a[15:0]]; e_lit_en = 1'b1; e_lit = lit;
            @(posedge clock); mhit++; #1;
        end else begin
            e_stall = 1'b1; e_mr = 1'b1; e_maddr_en = 1'b1; e_maddr = {a[31:2], 2'b00};
            e_rd_en = 1'b1; e_rdata = 32'd0;
            @(posedge clock); mmiss++; #1;
            e_mr = 1'b0; e_maddr_en = 1'b0;
            @(posedge clock); mvld[i] = 1'b1; mtag[i] = t; #1;
            e_stall = 1'b0; e_rdata = gold[a[15:0]]; e_lit_en = 1'b1; e_lit = lit;
            @(posedge clock); #1;
        end
        cpu_read = 1'b0; e_en = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        cpu_read = 1'b0; cpu_write = 1'b1; cpu_addr = a; cpu_wdata = d;
        exp_clear();
        e_mw = 1'b1; e_maddr_en = 1'b1; e_maddr = a; e_mwdata_en = 1'b1; e_mwdata = d;
        e_rd_en = 1'b1; e_rdata = 32'd0;
        @(posedge clock); gold[a[15:0]] = d; #1;
        cpu_write = 1'b0; e_en = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 65536; k++) begin
            ram[k]  = 32'(10 * k + 1);
            gold[k] = 32'(10 * k + 1);
        end
        for (int k = 0; k < 16; k++) begin
            mvld[k] = 1'b0;
            mtag[k] = '0;
        end
        mhit = 0; mmiss = 0; e_en = 1'b0;
        reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;

        // Reset with a request presented: memory strobes must stay low.
        @(posedge clock); #1;
        cpu_read = 1'b1; cpu_write = 1'b1; cpu_addr = 32'd5; cpu_wdata = 32'h1234;
        exp_clear(); e_stall_en = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
        exp_clear();
        @(posedge clock); #1;
        e_en = 1'b0;
        chk("reset_hit_count", hit_count, 32'd0);
        chk("reset_miss_count", miss_count, 32'd0);

        do_read(32'd5, 32'd51);
        chk("miss_after_5", miss_count, 32'd1);
        chk("hit_after_5", hit_count, 32'd0);
        do_read(32'd6, 32'd61);
        chk("hit_after_6", hit_count, 32'd1);

        do_write(32'd6, 32'hDEAD);
        do_read(32'd6, 32'hDEAD);
        chk("ram6_written", ram[6], 32'hDEAD);

        do_read(32'd69, 32'd691);
        do_read(32'd5, 32'd51);
        chk("miss_after_alias", miss_count, 32'd3);

        do_write(32'd200, 32'd7);
        chk("miss_after_wmiss", miss_count, 32'd3);
        do_read(32'd200, 32'd7);
        chk("miss_after_200", miss_count, 32'd4);

        do_read(32'h0000_0000, 32'd1);
        do_read(32'h0001_0000, 32'd1);
        do_read(32'h0000_FFFF, 32'd655351);
        do_read(32'h0000_0000, 32'd1);
        chk("hit_before_reset", hit_count, 32'd4);
        chk("miss_before_reset", miss_count, 32'd6);

        // Reset in the FILL cycle of a read of 8.
        cpu_read = 1'b1; cpu_addr = 32'd8;
        exp_clear(); e_stall = 1'b1; e_mr = 1'b1; e_maddr_en = 1'b1; e_maddr = 32'd8;
        @(posedge clock); mmiss++; #1;
        reset = 1'b1;
        exp_clear(); e_stall_en = 1'b0;
        @(posedge clock);
        for (int k = 0; k < 16; k++) mvld[k] = 1'b0;
        mhit = 0; mmiss = 0;
        #1;
        reset = 1'b0; cpu_read = 1'b0;
        exp_clear();
        @(posedge clock); #1;
        e_en = 1'b0;
        do_read(32'd8, 32'd81);
        chk("miss_after_rst", miss_count, 32'd1);
        chk("hit_after_rst", hit_count, 32'd0);

        @(posedge clock); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
